// File: rtl/eth_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_fifo_pkg
// Description : Shared definitions for the Ethernet/SD data-path FIFOs.
//               Holds the FWFT mode encoding, reset values and the level and
//               threshold compare helpers. The sync and async FIFO variants
//               both use this package.
// Revision    : 1.0  initial release
// ============================================================================
package eth_fifo_pkg;

    // Read-side behaviour selector for the FWFT parameter
    localparam int c_FWFT_OFF = 0;   // registered read, data one cycle after rd_en
    localparam int c_FWFT_ON  = 1;   // head word presented while not empty

    // Flag values driven while reset is asserted
    localparam logic c_RST_EMPTY        = 1'b1;
    localparam logic c_RST_ALMOST_EMPTY = 1'b1;
    localparam logic c_RST_FULL         = 1'b0;
    localparam logic c_RST_ALMOST_FULL  = 1'b0;
    localparam logic c_RST_ERR          = 1'b0;

    // Threshold compares run at 32 bits, so callers zero-extend the level.
    function automatic logic level_at_or_above(input logic [31:0] level,
                                               input logic [31:0] thr);
        return (level >= thr);
    endfunction

    function automatic logic level_at_or_below(input logic [31:0] level,
                                               input logic [31:0] thr);
        return (level <= thr);
    endfunction

endpackage : eth_fifo_pkg
`default_nettype wire

// File: rtl/eth_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : eth_fifo_ram
// Description : Simple dual-port RAM with one write port and one read port.
//               REG_READ=1 registers the read data, which updates only on
//               rd_en and resets to zero. REG_READ=0 gives a combinational
//               read of rd_addr.
// Ports       : clk, rst_n               clock and async active-low reset
//               wr_en, wr_addr, wr_data  write port
//               rd_en, rd_addr, rd_data  read port
// Revision    : 1.0  initial release
// ============================================================================
module eth_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int REG_READ   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];

    // Storage carries no reset, so it can map onto block or distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    if (REG_READ != 0) begin : g_reg_rd
        logic [DATA_WIDTH-1:0] r_rd_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_q <= '0;
            end else if (rd_en) begin
                r_rd_q <= r_mem[rd_addr];
            end
        end

        assign rd_data = r_rd_q;
    end else begin : g_comb_rd
        // In this mode the read is always open, so rd_en and rst_n are unused.
        logic w_unused_ok;
        assign w_unused_ok = &{1'b0, rd_en, rst_n};
        assign rd_data     = r_mem[rd_addr];
    end

endmodule : eth_fifo_ram
`default_nettype wire

// File: rtl/eth_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eth_sync_fifo_ctrl
// Description : Single-clock parametrised FIFO for the Ethernet/SD data path.
//               Provides optional first-word-fall-through, a live fill level,
//               programmable almost-full and almost-empty thresholds, and
//               sticky overflow/underflow flags.
// Ports       : clk, rst_n                    clock, async active-low reset
//               wr_data, wr_en, wr_full       write side
//               almost_full                   level >= ALMOST_FULL_NUM
//               rd_en, rd_data, rd_empty      read side
//               almost_empty                  level <= ALMOST_EMPTY_NUM
//               water_level                   stored words, 0..2**DEPTH_WIDTH
//               err_clr, overflow, underflow  sticky error flags and clear
// Revision    : 1.0  initial release
// ============================================================================
module eth_sync_fifo_ctrl
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 7,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 124,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [DEPTH_WIDTH:0] c_LVL_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
    localparam logic [DEPTH_WIDTH:0] c_LVL_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [31:0]          c_AF_THR   = 32'(ALMOST_FULL_NUM);
    localparam logic [31:0]          c_AE_THR   = 32'(ALMOST_EMPTY_NUM);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (DATA_WIDTH < 1 || DATA_WIDTH > 1152) begin : g_chk_dw
        $error("eth_sync_fifo_ctrl: DATA_WIDTH out of range 1..1152");
    end
    if (DEPTH_WIDTH < 4 || DEPTH_WIDTH > 16) begin : g_chk_depth
        $error("eth_sync_fifo_ctrl: DEPTH_WIDTH out of range 4..16");
    end
    if (FWFT != c_FWFT_OFF && FWFT != c_FWFT_ON) begin : g_chk_fwft
        $error("eth_sync_fifo_ctrl: FWFT must be 0 or 1");
    end
    if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > (1 << DEPTH_WIDTH)) begin : g_chk_af
        $error("eth_sync_fifo_ctrl: ALMOST_FULL_NUM out of range 1..2**DEPTH_WIDTH");
    end
    if (ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > (1 << DEPTH_WIDTH) - 1) begin : g_chk_ae
        $error("eth_sync_fifo_ctrl: ALMOST_EMPTY_NUM out of range 0..2**DEPTH_WIDTH-1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DEPTH_WIDTH:0]  r_wr_ptr;
    logic [DEPTH_WIDTH:0]  r_rd_ptr;
    logic [DEPTH_WIDTH:0]  r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DEPTH_WIDTH:0]  w_level_nxt;
    logic [DATA_WIDTH-1:0] w_ram_q;

    // Acceptance uses only this cycle's registered flags. A read never frees
    // room for a write in the same cycle, and a write never feeds a read in
    // the same cycle.
    assign w_wr_acc = wr_en && !r_full;
    assign w_rd_acc = rd_en && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + c_LVL_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_level_nxt = r_level - c_LVL_ONE;
        end
    end

    // Pointers wrap naturally. Their MSB separates full from empty, while
    // the flags come from the next-level count so they stay consistent with
    // water_level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= c_RST_FULL;
            r_empty  <= c_RST_EMPTY;
            r_afull  <= c_RST_ALMOST_FULL;
            r_aempty <= c_RST_ALMOST_EMPTY;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_LVL_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_LVL_ONE;
            end
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == c_LVL_FULL);
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= level_at_or_above(32'(w_level_nxt), c_AF_THR);
            r_aempty <= level_at_or_below(32'(w_level_nxt), c_AE_THR);
        end
    end

    // A new error in the same cycle takes priority over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= c_RST_ERR;
            r_underflow <= c_RST_ERR;
        end else begin
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    eth_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH),
        .REG_READ   ((FWFT == c_FWFT_ON) ? 0 : 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr[DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr[DEPTH_WIDTH-1:0]),
        .rd_data (w_ram_q)
    );

    if (FWFT == c_FWFT_ON) begin : g_fwft
        // While the FIFO is empty, the RAM slot at rd_ptr is stale or was
        // never written. To avoid presenting it, keep a copy of the last head
        // word seen and drive that copy. It resets to zero.
        logic [DATA_WIDTH-1:0] r_head_hold;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_head_hold <= '0;
            end else if (!r_empty) begin
                r_head_hold <= w_ram_q;
            end
        end

        assign rd_data = r_empty ? r_head_hold : w_ram_q;
    end else begin : g_std
        assign rd_data = w_ram_q;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wr_full      = r_full;
    assign almost_full  = r_afull;
    assign rd_empty     = r_empty;
    assign almost_empty = r_aempty;
    assign water_level  = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : eth_sync_fifo_ctrl
`default_nettype wire

// File: tb/tb_eth_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_sync_fifo_ctrl
// Description : Self-checking bench for eth_sync_fifo_ctrl. It uses a
//               standard-read instance driven through a table plus scoreboard
//               sequences, and a small FWFT instance for fall-through checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_eth_sync_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Standard-read instance
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        err_clr = 1'b0;
    logic        wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
    logic [31:0] rd_data;
    logic [7:0]  water_level;

    // FWFT instance
    logic [31:0] f_wr_data = '0;
    logic        f_wr_en = 1'b0;
    logic        f_rd_en = 1'b0;
    logic        f_err_clr = 1'b0;
    logic        f_wr_full, f_almost_full, f_rd_empty, f_almost_empty, f_overflow, f_underflow;
    logic [31:0] f_rd_data;
    logic [7:0]  f_water_level;

    always #5 clk = ~clk;

    eth_sync_fifo_ctrl #(
        .DATA_WIDTH(32), .DEPTH_WIDTH(7), .FWFT(0),
        .ALMOST_FULL_NUM(124), .ALMOST_EMPTY_NUM(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty),
        .water_level(water_level), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    eth_sync_fifo_ctrl #(
        .DATA_WIDTH(32), .DEPTH_WIDTH(7), .FWFT(1),
        .ALMOST_FULL_NUM(124), .ALMOST_EMPTY_NUM(4)
    ) dut_f (
        .clk(clk), .rst_n(rst_n),
        .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_full(f_wr_full), .almost_full(f_almost_full),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_empty(f_rd_empty), .almost_empty(f_almost_empty),
        .water_level(f_water_level), .err_clr(f_err_clr),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of the standard-read instance
    logic [31:0] sb[$];
    int          m_lvl = 0;
    logic [31:0] m_rd  = '0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    typedef struct {
        logic        w;
        logic        r;
        logic        c;
        logic [31:0] d;
        logic [7:0]  lvl;
        logic        empty;
        logic        unf;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        sb.delete();
        m_lvl = 0;
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".level"}, 64'(water_level), 64'(m_lvl));
        chk({tag, ".full"}, 64'(wr_full), 64'(m_lvl == 128));
        chk({tag, ".empty"}, 64'(rd_empty), 64'(m_lvl == 0));
        chk({tag, ".afull"}, 64'(almost_full), 64'(m_lvl >= 124));
        chk({tag, ".aempty"}, 64'(almost_empty), 64'(m_lvl <= 4));
        chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".unf"}, 64'(underflow), 64'(m_unf));
        chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_rd));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".level"}, 64'(water_level), 64'd0);
        chk({tag, ".empty"}, 64'(rd_empty), 64'd1);
        chk({tag, ".aempty"}, 64'(almost_empty), 64'd1);
        chk({tag, ".full"}, 64'(wr_full), 64'd0);
        chk({tag, ".afull"}, 64'(almost_full), 64'd0);
        chk({tag, ".rd_data"}, 64'(rd_data), 64'd0);
        chk({tag, ".ovf"}, 64'(overflow), 64'd0);
        chk({tag, ".unf"}, 64'(underflow), 64'd0);
    endtask

    // One clock on the standard instance. Inputs are applied at the negedge,
    // the model is updated, and the outputs are checked at the next negedge.
    task automatic drive(input logic w, input logic r, input logic c,
                         input logic [31:0] d, input string tag);
        logic wacc, racc;
        wr_en   = w;
        rd_en   = r;
        err_clr = c;
        wr_data = d;
        wacc = w && (m_lvl < 128);
        racc = r && (m_lvl > 0);
        if (w && !wacc) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && !racc) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        if (racc) begin
            if (sb.size() == 0) begin
                bad++;
                total++;
                $display("FAIL %s.sb_empty: got 0 want 1", tag);
            end else begin
                m_rd = sb.pop_front();
            end
        end
        if (wacc) sb.push_back(d);
        m_lvl = m_lvl + (wacc ? 1 : 0) - (racc ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        chk_model(tag);
    endtask

    task automatic f_step(input logic w, input logic r, input logic [31:0] d);
        f_wr_en   = w;
        f_rd_en   = r;
        f_wr_data = d;
        @(posedge clk);
        @(negedge clk);
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
    endtask

    initial begin
        // Table rows: {wr, rd, clr, data, exp level, exp empty, exp underflow, exp rd_data}
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        8'd0, 1'b1, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,        8'd0, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h11111111, 8'd1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h22222222, 8'd2, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h33333333, 8'd2, 1'b0, 1'b0, 32'h11111111};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        8'd1, 1'b0, 1'b0, 32'h22222222};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        8'd0, 1'b1, 1'b0, 32'h33333333};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0,        8'd0, 1'b1, 1'b1, 32'h33333333};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,        8'd0, 1'b1, 1'b0, 32'h33333333};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h44444444, 8'd1, 1'b0, 1'b0, 32'h33333333};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'd0, 1'b1, 1'b0, 32'h44444444};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].d, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tlevel", i), 64'(water_level), 64'(vecs[i].lvl));
            chk($sformatf("vec%0d.tempty", i), 64'(rd_empty), 64'(vecs[i].empty));
            chk($sformatf("vec%0d.tunf", i), 64'(underflow), 64'(vecs[i].unf));
            chk($sformatf("vec%0d.trd", i), 64'(rd_data), 64'(vecs[i].rd));
        end

        // ---------------- fill to full ----------------
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF - 32'(i), "fill");
            if (i == 122) chk("fill.af_at123", 64'(almost_full), 64'd0);
            if (i == 123) chk("fill.af_at124", 64'(almost_full), 64'd1);
        end
        chk("fill.full", 64'(wr_full), 64'd1);
        chk("fill.level128", 64'(water_level), 64'd128);
        drive(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, "fill_ovf");
        chk("fill.ovf", 64'(overflow), 64'd1);
        chk("fill.ovf_level", 64'(water_level), 64'd128);
        drive(1'b0, 1'b0, 1'b1, 32'h0, "fill_clr");

        // ---------------- drain ----------------
        for (int i = 0; i < 128; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, "drain");
            chk("drain.data", 64'(rd_data), 64'(32'hFFFFFFFF - 32'(i)));
            if (i == 123) chk("drain.ae_at4", 64'(almost_empty), 64'd1);
            if (i == 122) chk("drain.ae_at5", 64'(almost_empty), 64'd0);
        end
        chk("drain.empty", 64'(rd_empty), 64'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, "drain_unf");
        chk("drain.unf", 64'(underflow), 64'd1);
        chk("drain.held", 64'(rd_data), 64'h0000_0000_FFFF_FF80);
        drive(1'b0, 1'b0, 1'b1, 32'h0, "drain_clr");

        // ---------------- streaming at level 64 ----------------
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 1'b0, 32'h1000_0000 + 32'(i), "pre64");
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h2000_0000 + 32'(i), "stream");
        end
        chk("stream.level64", 64'(water_level), 64'd64);

        // ---------------- wr+rd at full ----------------
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 1'b0, 32'h3000_0000 + 32'(i), "top");
        chk("top.full", 64'(wr_full), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 32'hBAD0BAD0, "full_wr_rd");
        chk("full_wr_rd.ovf", 64'(overflow), 64'd1);
        chk("full_wr_rd.level", 64'(water_level), 64'd127);
        drive(1'b1, 1'b0, 1'b0, 32'h4000_0000, "refill");
        drive(1'b1, 1'b0, 1'b1, 32'h4000_0001, "ovf_vs_clr");
        chk("ovf_vs_clr.ovf", 64'(overflow), 64'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h0, "ovf_clr");
        chk("ovf_clr.ovf", 64'(overflow), 64'd0);

        // ---------------- async reset mid-burst at level 50 ----------------
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b0, 1'b0, 32'h5000_0000 + 32'(i), "lvl50");
        chk("lvl50.level", 64'(water_level), 64'd50);
        wr_en   = 1'b1;
        wr_data = 32'h5555_5555;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        m_reset();
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_model("after_rst");

        // ---------------- FWFT instance ----------------
        chk("fwft.rst_data", 64'(f_rd_data), 64'd0);
        chk("fwft.rst_empty", 64'(f_rd_empty), 64'd1);
        f_step(1'b1, 1'b0, 32'hA5A5A5A5);
        chk("fwft.w1_empty", 64'(f_rd_empty), 64'd0);
        chk("fwft.w1_data", 64'(f_rd_data), 64'hA5A5A5A5);
        chk("fwft.w1_level", 64'(f_water_level), 64'd1);
        f_step(1'b1, 1'b0, 32'h12345678);
        chk("fwft.w2_head", 64'(f_rd_data), 64'hA5A5A5A5);
        f_step(1'b0, 1'b1, 32'h0);
        chk("fwft.pop1_data", 64'(f_rd_data), 64'h12345678);
        chk("fwft.pop1_level", 64'(f_water_level), 64'd1);
        f_step(1'b0, 1'b1, 32'h0);
        chk("fwft.pop2_empty", 64'(f_rd_empty), 64'd1);
        chk("fwft.pop2_held", 64'(f_rd_data), 64'h12345678);
        f_step(1'b0, 1'b1, 32'h0);
        chk("fwft.unf", 64'(f_underflow), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_eth_sync_fifo_ctrl
`default_nettype wire
